// File: rtl/dct_sequencer.sv
// dct_sequencer: latches one 8x8 YCbCr block, steps the DCT datapath over all 64 (u,v) selects and streams the results.
// Define DCT_ZIGZAG_ORDER_EN to visit coefficients in JPEG zigzag order instead of raster order.
module dct_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] Y_in,
  input  logic [511:0] Cr_in,
  input  logic [511:0] Cb_in,
  output logic [511:0] dct_Y_in,
  output logic [511:0] dct_Cr_in,
  output logic [511:0] dct_Cb_in,
  output logic [2:0]   dct_u,
  output logic [2:0]   dct_v,
  input  logic [13:0]  dct_Y_out,
  input  logic [13:0]  dct_Cr_out,
  input  logic [13:0]  dct_Cb_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [13:0]  Y_coef,
  output logic [13:0]  Cr_coef,
  output logic [13:0]  Cb_coef,
  output logic [5:0]   coef_index,
  output logic         out_last,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, EMIT} state_t;
  state_t state, state_nxt;
  logic [5:0] k;
  logic [3:0] cnt;
  logic accept, settle_done, handshake;
`ifdef DCT_ZIGZAG_ORDER_EN
  // entry k holds {v,u} of the k-th zigzag coefficient
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};
  function automatic logic [5:0] uv_of(input logic [5:0] idx);
    return ZZ[idx];
  endfunction
`else
  function automatic logic [5:0] uv_of(input logic [5:0] idx);
    return idx;
  endfunction
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = accept ? SETTLE :
                settle_done ? EMIT :
                handshake ? (k == 6'd63 ? IDLE : SETTLE) :
                (state == SETTLE || state == EMIT) ? state : IDLE;
  // in_ready also looks at reset so it reads 0 while reset is held
  always_comb begin
    in_ready    = (state == IDLE) && reset;
    out_valid   = (state == EMIT);
    busy        = (state != IDLE);
    accept      = in_ready && in_valid;
    settle_done = (state == SETTLE) && (cnt == 4'(SETTLE_CYCLES - 1));
    handshake   = out_valid && out_ready;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dct_Y_in   <= '0;
      dct_Cr_in  <= '0;
      dct_Cb_in  <= '0;
      dct_u      <= '0;
      dct_v      <= '0;
      k          <= '0;
      cnt        <= '0;
      Y_coef     <= '0;
      Cr_coef    <= '0;
      Cb_coef    <= '0;
      coef_index <= '0;
      out_last   <= 1'b0;
    end else begin
      if (accept) begin
        dct_Y_in       <= Y_in;
        dct_Cr_in      <= Cr_in;
        dct_Cb_in      <= Cb_in;
        k              <= '0;
        cnt            <= '0;
        {dct_v, dct_u} <= uv_of(6'd0);
      end
      if (state == SETTLE) cnt <= settle_done ? 4'd0 : cnt + 4'd1;
      if (settle_done) begin
        Y_coef     <= dct_Y_out;
        Cr_coef    <= dct_Cr_out;
        Cb_coef    <= dct_Cb_out;
        coef_index <= k;
        out_last   <= (k == 6'd63);
      end
      if (handshake && k != 6'd63) begin
        k              <= k + 6'd1;
        {dct_v, dct_u} <= uv_of(k + 6'd1);
      end
    end
endmodule
